axi_lite_master: RTL and testbench
==================================

# axi_lite_master

Single-outstanding AXI-Lite master that turns simple command/response requests from local control logic (sequencers, test drivers, config loaders) into AXI-Lite write and read transactions. It is the initiator end of the AXI-Lite register buses in this design and drives our register-file bridges and other AXI-Lite slaves. A per-transaction timeout guarantees that every accepted command gets a response, even if a slave never responds.

## Interface
- ADDR_WIDTH, 8, width of cmd_addr, m_axi_awaddr, m_axi_araddr
- DATA_WIDTH, 32, width of all data buses
- TIMEOUT, 256, maximum cycles a transaction may spend in AXI phases; 0 disables the timeout
- clk  in  1  single clock; all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE and while rst is low
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WIDTH  byte address, passed through unmodified
- cmd_wdata  in  DATA_WIDTH  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and timeouts
- rsp_resp  out  2  captured BRESP/RRESP; 2'b10 on timeout
- rsp_timeout  out  1  response was generated by timeout
- m_axi_awaddr/awvalid out, m_axi_awready in  AW channel
- m_axi_wdata/wvalid out, m_axi_wready in  W channel
- m_axi_bresp[1:0]/bvalid in, m_axi_bready out  B channel
- m_axi_araddr/arvalid out, m_axi_arready in  AR channel
- m_axi_rdata/rresp[1:0]/rvalid in, m_axi_rready out  R channel

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE: a command is accepted on cmd_valid && cmd_ready. Address, data, and write flag are latched, and the timeout counter is cleared. The next state is WR_REQ or RD_REQ.
- WR_REQ: awvalid and wvalid both assert in the first cycle. Each valid drops independently on the edge where its own handshake (valid && ready) occurs; it is never re-raised. When both handshakes are done (same edge or different edges), the next state is WR_RESP.
- WR_RESP: bready = 1. When bvalid is seen, bresp is captured into rsp_resp, rsp_rdata is set to 0, and the next state is RSP.
- RD_REQ: arvalid = 1 until arready; then the next state is RD_RESP.
- RD_RESP: rready = 1. When rvalid is seen, rdata and rresp are captured and the next state is RSP.
- RSP: rsp_valid = 1. The payload is held stable until rsp_ready; then the next state is IDLE. No AXI signal is active in RSP or IDLE.
- Valid signals are asserted without waiting for ready. Apart from timeout and reset, a valid is never withdrawn before its handshake.
- Timeout (TIMEOUT > 0):
  - The counter increments every cycle in WR_REQ, WR_RESP, RD_REQ, and RD_RESP.
  - If the counter equals TIMEOUT-1 and the current phase does not complete on that edge, the next state is RSP with rsp_resp = 2'b10, rsp_timeout = 1, and rsp_rdata = 0. All AXI valid and ready outputs drop on that edge.
  - If completion and timeout happen on the same edge, completion wins.
  - A B or R beat that arrives after a timeout is not consumed. Bus recovery is the system's responsibility.
- Counter width is clog2(TIMEOUT+1). TIMEOUT = 0 means the counter is held at 0 and never fires.
- Reset: every output goes to 0 on the edge where rst is high (valids, readies, addresses, data, rsp_*; cmd_ready = 0 while rst is high). The state becomes IDLE.
- Reset mid-transaction: the transaction is abandoned with no response, and all outputs are 0 on the next edge.

## Timing
- Accept at edge E0:
  - AW/W/AR valids are high in the cycle after E0.
  - With an always-ready slave, the address/data handshake is at E1. bready/rready are high in the cycle after E1.
  - The earliest B/R beat is at E2. rsp_valid is high in the cycle after E2.
  - With rsp_ready high, the response handshake is at E3 and cmd_ready is high in the cycle after E3.
- Minimum: 4 cycles per command. Only one transaction is outstanding at a time.
- A timeout drops the valid after exactly TIMEOUT cycles high. rsp_valid rises on the next cycle.
- All outputs are registered except cmd_ready, which is decoded from the state register and rst.

## Test plan
- Write: addr 0x08, data 0xDEADBEEF, slave always ready, bresp 00 -> one AW and one W handshake at E1, rsp_valid in the cycle after E2, rsp_resp 00, rsp_timeout 0, rsp_rdata 0.
- Read: addr 0x08, slave returns 0xDEADBEEF with rvalid 5 cycles after AR -> rready held the whole time, rsp_rdata 0xDEADBEEF, rsp_resp 00.
- Skewed write: awready 1 cycle after valid, wready 4 cycles after valid -> awvalid low after its handshake while wvalid is still held, exactly one handshake per channel, bready only after both.
- Timeout: TIMEOUT=16, read, arready stuck at 0 -> arvalid high exactly 16 cycles then low, rsp_resp 2'b10, rsp_timeout 1, rsp_rdata 0. A second run with arready arriving on cycle 16 -> normal completion, rsp_timeout 0.
- Backpressure: rsp_ready low for 10 cycles while cmd_valid is high -> rsp_valid and payload stable, cmd_ready 0, no AXI valid asserted, next command accepted the cycle after the rsp handshake.
- Reset in WR_RESP: rst high for 1 cycle -> all outputs 0 on the next edge, cmd_ready 1 in the first cycle with rst low, no rsp_valid for the abandoned write.

Source files
------------

// File: rtl/axi_lite_master.sv
// axi_lite_master: single-outstanding AXI-Lite initiator.
// A per-transaction timeout guarantees every accepted command gets a response.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  output logic [ADDR_WIDTH-1:0] m_axi_araddr,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  input  logic [DATA_WIDTH-1:0] m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP
  } state_t;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  wvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  rready;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_resp;
    logic                  rsp_timeout;
  } out_t;

  state_t        state, state_n;
  out_t          q, d;
  logic [CW-1:0] cnt;
  logic          accept, in_axi, tmo, done;

  assign cmd_ready = (state == IDLE) && !rst;
  assign accept    = cmd_valid && cmd_ready;
  assign in_axi    = (state == WR_REQ) || (state == WR_RESP) ||
                     (state == RD_REQ) || (state == RD_RESP);
  // Counter saturates, so a phase entered after a late completion
  // still expires on its first cycle without a beat.
  assign tmo = (TIMEOUT != 0) && in_axi && (cnt >= CNT_LAST);

  always_comb begin
    done = 1'b0;
    unique case (state)
      WR_REQ:  done = (!q.awvalid || m_axi_awready) &&
                      (!q.wvalid || m_axi_wready);
      WR_RESP: done = m_axi_bvalid;
      RD_REQ:  done = m_axi_arready;
      RD_RESP: done = m_axi_rvalid;
      default: done = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      q     <= d;
      if (accept || TIMEOUT == 0)
        cnt <= '0;
      else if (in_axi && cnt != CNT_MAX)
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept)
                 state_n = cmd_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (done)     state_n = WR_RESP;
               else if (tmo) state_n = RSP;
      WR_RESP: if (done || tmo) state_n = RSP;
      RD_REQ:  if (done)     state_n = RD_RESP;
               else if (tmo) state_n = RSP;
      RD_RESP: if (done || tmo) state_n = RSP;
      RSP:     if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  function automatic out_t expire(input out_t o);
    out_t r;
    r             = o;
    r.awvalid     = 1'b0;
    r.wvalid      = 1'b0;
    r.bready      = 1'b0;
    r.arvalid     = 1'b0;
    r.rready      = 1'b0;
    r.rsp_valid   = 1'b1;
    r.rsp_rdata   = '0;
    r.rsp_resp    = 2'b10;
    r.rsp_timeout = 1'b1;
    return r;
  endfunction

  always_comb begin
    d = q;
    unique case (state)
      IDLE: begin
        if (accept) begin
          d.awaddr  = cmd_addr;
          d.araddr  = cmd_addr;
          d.wdata   = cmd_wdata;
          d.awvalid = cmd_write;
          d.wvalid  = cmd_write;
          d.arvalid = !cmd_write;
        end
      end
      WR_REQ: begin
        d.awvalid = q.awvalid && !m_axi_awready;
        d.wvalid  = q.wvalid && !m_axi_wready;
        if (done)     d.bready = 1'b1;
        else if (tmo) d = expire(q);
      end
      WR_RESP: begin
        if (done) begin
          d.bready      = 1'b0;
          d.rsp_valid   = 1'b1;
          d.rsp_rdata   = '0;
          d.rsp_resp    = m_axi_bresp;
          d.rsp_timeout = 1'b0;
        end else if (tmo) begin
          d = expire(q);
        end
      end
      RD_REQ: begin
        if (done) begin
          d.arvalid = 1'b0;
          d.rready  = 1'b1;
        end else if (tmo) begin
          d = expire(q);
        end
      end
      RD_RESP: begin
        if (done) begin
          d.rready      = 1'b0;
          d.rsp_valid   = 1'b1;
          d.rsp_rdata   = m_axi_rdata;
          d.rsp_resp    = m_axi_rresp;
          d.rsp_timeout = 1'b0;
        end else if (tmo) begin
          d = expire(q);
        end
      end
      RSP: if (rsp_ready) d.rsp_valid = 1'b0;
      default: d = q;
    endcase
  end

  assign m_axi_awaddr  = q.awaddr;
  assign m_axi_awvalid = q.awvalid;
  assign m_axi_wdata   = q.wdata;
  assign m_axi_wvalid  = q.wvalid;
  assign m_axi_bready  = q.bready;
  assign m_axi_araddr  = q.araddr;
  assign m_axi_arvalid = q.arvalid;
  assign m_axi_rready  = q.rready;
  assign rsp_valid     = q.rsp_valid;
  assign rsp_rdata     = q.rsp_rdata;
  assign rsp_resp      = q.rsp_resp;
  assign rsp_timeout   = q.rsp_timeout;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb_axi_lite_master: directed bench with a configurable AXI-Lite
// slave model and a response scoreboard.
module tb_axi_lite_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  typedef struct {
    logic [DW-1:0] rdata;
    logic [1:0]    resp;
    logic          tmo;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          rsp_timeout;
  logic [AW-1:0] m_axi_awaddr;
  logic          m_axi_awvalid, m_axi_awready;
  logic [DW-1:0] m_axi_wdata;
  logic          m_axi_wvalid, m_axi_wready;
  logic [1:0]    m_axi_bresp;
  logic          m_axi_bvalid, m_axi_bready;
  logic [AW-1:0] m_axi_araddr;
  logic          m_axi_arvalid, m_axi_arready;
  logic [DW-1:0] m_axi_rdata;
  logic [1:0]    m_axi_rresp;
  logic          m_axi_rvalid, m_axi_rready;

  axi_lite_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid),
    .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
    .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  always #5 clk = ~clk;

  // slave model knobs
  int            aw_lat = 0, w_lat = 0, ar_lat = 0;
  int            r_lat = 0, b_lat = 0;
  bit            ar_stuck = 1'b0;
  logic [DW-1:0] r_val = '0;
  logic [1:0]    r_code = 2'b00, b_code = 2'b00;

  int   aw_wait = 0, w_wait = 0, ar_wait = 0;
  int   b_wait = 0, r_wait = 0;
  logic aw_got = 1'b0, w_got = 1'b0;
  logic b_pend = 1'b0, r_pend = 1'b0;
  logic aw_hs, w_hs, ar_hs, b_hs, r_hs;

  assign m_axi_awready = m_axi_awvalid && (aw_wait == aw_lat);
  assign m_axi_wready  = m_axi_wvalid && (w_wait == w_lat);
  assign m_axi_arready = m_axi_arvalid && !ar_stuck &&
                         (ar_wait == ar_lat);
  assign m_axi_bvalid  = b_pend && (b_wait >= b_lat);
  assign m_axi_bresp   = m_axi_bvalid ? b_code : 2'b00;
  assign m_axi_rvalid  = r_pend && (r_wait >= r_lat);
  assign m_axi_rdata   = m_axi_rvalid ? r_val : '0;
  assign m_axi_rresp   = m_axi_rvalid ? r_code : 2'b00;

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  assign ar_hs = m_axi_arvalid && m_axi_arready;
  assign b_hs  = m_axi_bvalid && m_axi_bready;
  assign r_hs  = m_axi_rvalid && m_axi_rready;

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0;
      b_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0;
      b_pend <= 1'b0; r_pend <= 1'b0;
    end else begin
      aw_wait <= (m_axi_awvalid && !aw_hs) ? aw_wait + 1 : 0;
      w_wait  <= (m_axi_wvalid && !w_hs) ? w_wait + 1 : 0;
      ar_wait <= (m_axi_arvalid && !ar_hs) ? ar_wait + 1 : 0;
      if (b_pend) begin
        if (b_hs) b_pend <= 1'b0;
        else      b_wait <= b_wait + 1;
      end else if ((aw_got || aw_hs) && (w_got || w_hs)) begin
        b_pend <= 1'b1; b_wait <= 0;
        aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_got || aw_hs;
        w_got  <= w_got || w_hs;
      end
      if (r_pend) begin
        if (r_hs) r_pend <= 1'b0;
        else      r_wait <= r_wait + 1;
      end else if (ar_hs) begin
        r_pend <= 1'b1; r_wait <= 0;
      end
    end
  end

  // monitors: edge index of the latest handshakes, level counters
  int            cyc = 0;
  int            aw_n = 0, w_n = 0, ar_n = 0;
  int            aw_cyc = 0, w_cyc = 0, ar_cyc = 0, acc_cyc = 0;
  int            rr_hi = 0, ar_hi = 0, skew_n = 0, rsp_hi = 0;
  int            br_rise = 0;
  logic          br_prev = 1'b0;
  logic [AW-1:0] aw_addr_seen = '0, ar_addr_seen = '0;
  logic [DW-1:0] w_data_seen = '0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aw_hs) begin
      aw_n <= aw_n + 1; aw_cyc <= cyc + 1;
      aw_addr_seen <= m_axi_awaddr;
    end
    if (w_hs) begin
      w_n <= w_n + 1; w_cyc <= cyc + 1;
      w_data_seen <= m_axi_wdata;
    end
    if (ar_hs) begin
      ar_n <= ar_n + 1; ar_cyc <= cyc + 1;
      ar_addr_seen <= m_axi_araddr;
    end
    if (cmd_valid && cmd_ready) acc_cyc <= cyc + 1;
    if (m_axi_rready) rr_hi <= rr_hi + 1;
  end

  always @(negedge clk) begin
    if (m_axi_arvalid) ar_hi <= ar_hi + 1;
    if (!m_axi_awvalid && m_axi_wvalid) skew_n <= skew_n + 1;
    if (rsp_valid) rsp_hi <= rsp_hi + 1;
    if (m_axi_bready && !br_prev) br_rise <= cyc;
    br_prev <= m_axi_bready;
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input bit wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] dt, input exp_t e,
                      output int e0);
    int n = 0;
    cmd_write = wr; cmd_addr = a; cmd_wdata = dt; cmd_valid = 1'b1;
    while (!cmd_ready && n < 40) begin
      @(negedge clk); n++;
    end
    chk("cmd_accept_wait", 64'(n < 40), 64'd1);
    @(posedge clk); #1;
    e0 = cyc;
    cmd_valid = 1'b0;
    sb.push_back(e);
  endtask

  task automatic compare_rsp(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() > 0), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(e.rdata));
      chk({tag, "_resp"}, 64'(rsp_resp), 64'(e.resp));
      chk({tag, "_timeout"}, 64'(rsp_timeout), 64'(e.tmo));
    end
  endtask

  task automatic recv(input string tag, output int seen);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 60) begin
      @(negedge clk); n++;
    end
    chk({tag, "_rsp_wait"}, 64'(n < 60), 64'd1);
    seen = cyc;
    compare_rsp(tag);
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, seen, n, bad, hcyc;
    int a0, w0, ar0, rr0, arh0, sk0, rh0;
    logic [DW-1:0] snap_d;
    logic [1:0]    snap_r;

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_valids", 64'({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid,
        m_axi_bready, m_axi_rready, rsp_valid}), 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);

    // basic write, always-ready slave
    a0 = aw_n; w0 = w_n;
    send(1'b1, 8'h08, 32'hDEADBEEF, '{32'h0, 2'b00, 1'b0}, e0);
    recv("wr", seen);
    chk("wr_aw_cyc", 64'(aw_cyc), 64'(e0 + 1));
    chk("wr_w_cyc", 64'(w_cyc), 64'(e0 + 1));
    chk("wr_aw_count", 64'(aw_n - a0), 64'd1);
    chk("wr_w_count", 64'(w_n - w0), 64'd1);
    chk("wr_awaddr", 64'(aw_addr_seen), 64'h08);
    chk("wr_wdata", 64'(w_data_seen), 64'hDEADBEEF);
    chk("wr_rsp_cyc", 64'(seen), 64'(e0 + 2));
    chk("wr_cmd_ready_after", 64'(cmd_ready), 64'd1);

    // read, R beat 5 cycles after AR
    r_lat = 5; r_val = 32'hDEADBEEF; rr0 = rr_hi;
    send(1'b0, 8'h08, 32'h0, '{32'hDEADBEEF, 2'b00, 1'b0}, e0);
    recv("rd", seen);
    chk("rd_ar_cyc", 64'(ar_cyc), 64'(e0 + 1));
    chk("rd_araddr", 64'(ar_addr_seen), 64'h08);
    chk("rd_rready_cycles", 64'(rr_hi - rr0), 64'd6);
    chk("rd_rsp_cyc", 64'(seen), 64'(e0 + 7));

    // error responses are passed through
    r_lat = 0; r_val = 32'h12345678; r_code = 2'b10;
    send(1'b0, 8'h44, 32'h0, '{32'h12345678, 2'b10, 1'b0}, e0);
    recv("rd_slverr", seen);
    r_code = 2'b00; b_code = 2'b01;
    send(1'b1, 8'h48, 32'h0, '{32'h0, 2'b01, 1'b0}, e0);
    recv("wr_exokay", seen);
    b_code = 2'b00;

    // skewed write
    aw_lat = 1; w_lat = 4;
    a0 = aw_n; w0 = w_n; sk0 = skew_n;
    send(1'b1, 8'h0C, 32'hA5A55A5A, '{32'h0, 2'b00, 1'b0}, e0);
    recv("skew", seen);
    chk("skew_aw_cyc", 64'(aw_cyc), 64'(e0 + 2));
    chk("skew_w_cyc", 64'(w_cyc), 64'(e0 + 5));
    chk("skew_aw_count", 64'(aw_n - a0), 64'd1);
    chk("skew_w_count", 64'(w_n - w0), 64'd1);
    chk("skew_w_only_cycles", 64'(skew_n - sk0), 64'd3);
    chk("skew_bready_rise", 64'(br_rise), 64'(e0 + 5));
    chk("skew_rsp_cyc", 64'(seen), 64'(e0 + 6));
    aw_lat = 0; w_lat = 0;

    // timeout with arready stuck low
    ar_stuck = 1'b1;
    ar0 = ar_n; arh0 = ar_hi; rr0 = rr_hi;
    send(1'b0, 8'h10, 32'h0, '{32'h0, 2'b10, 1'b1}, e0);
    recv("tmo", seen);
    chk("tmo_arvalid_cycles", 64'(ar_hi - arh0), 64'd16);
    chk("tmo_ar_count", 64'(ar_n - ar0), 64'd0);
    chk("tmo_rready_cycles", 64'(rr_hi - rr0), 64'd0);
    chk("tmo_rsp_cyc", 64'(seen), 64'(e0 + 16));
    ar_stuck = 1'b0;

    // arready on the last allowed cycle: completion wins
    ar_lat = 15; r_val = 32'h0BADF00D;
    ar0 = ar_n; arh0 = ar_hi;
    send(1'b0, 8'h14, 32'h0, '{32'h0BADF00D, 2'b00, 1'b0}, e0);
    recv("late", seen);
    chk("late_arvalid_cycles", 64'(ar_hi - arh0), 64'd16);
    chk("late_ar_cyc", 64'(ar_cyc), 64'(e0 + 16));
    chk("late_ar_count", 64'(ar_n - ar0), 64'd1);
    chk("late_rsp_cyc", 64'(seen), 64'(e0 + 17));
    ar_lat = 0;

    // response backpressure with next command waiting
    send(1'b1, 8'h20, 32'h11223344, '{32'h0, 2'b00, 1'b0}, e0);
    n = 0;
    while (!rsp_valid && n < 60) begin
      @(negedge clk); n++;
    end
    chk("bp_rsp_wait", 64'(n < 60), 64'd1);
    cmd_write = 1'b0; cmd_addr = 8'h24; cmd_valid = 1'b1;
    snap_d = rsp_rdata; snap_r = rsp_resp; bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== snap_d ||
          rsp_resp !== snap_r || rsp_timeout !== 1'b0 ||
          cmd_ready !== 1'b0 || m_axi_awvalid !== 1'b0 ||
          m_axi_wvalid !== 1'b0 || m_axi_arvalid !== 1'b0 ||
          m_axi_bready !== 1'b0 || m_axi_rready !== 1'b0)
        bad++;
    end
    chk("bp_stable_cycles_bad", 64'(bad), 64'd0);
    compare_rsp("bp");
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    hcyc = cyc;
    rsp_ready = 1'b0;
    r_val = 32'h55AA55AA;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("bp_next_accept_cyc", 64'(acc_cyc), 64'(hcyc + 1));
    sb.push_back('{32'h55AA55AA, 2'b00, 1'b0});
    recv("bp_next", seen);

    // reset while waiting for B
    b_lat = 8;
    send(1'b1, 8'h30, 32'hFEEDFACE, '{32'h0, 2'b00, 1'b0}, e0);
    n = 0;
    while (!m_axi_bready && n < 20) begin
      @(negedge clk); n++;
    end
    chk("rstwr_bready_wait", 64'(n < 20), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstwr_ctl_zero", 64'({m_axi_awvalid, m_axi_wvalid,
        m_axi_arvalid, m_axi_bready, m_axi_rready, rsp_valid,
        rsp_timeout, rsp_resp, cmd_ready}), 64'd0);
    chk("rstwr_data_zero", 64'({m_axi_awaddr, m_axi_araddr}), 64'd0);
    chk("rstwr_wdata_zero", 64'(m_axi_wdata), 64'd0);
    chk("rstwr_rdata_zero", 64'(rsp_rdata), 64'd0);
    rst = 1'b0;
    void'(sb.pop_back());
    b_lat = 0;
    #1;
    chk("rstwr_cmd_ready", 64'(cmd_ready), 64'd1);
    rh0 = rsp_hi;
    repeat (12) @(negedge clk);
    chk("rstwr_no_rsp", 64'(rsp_hi - rh0), 64'd0);

    // normal operation after reset
    r_val = 32'hCAFEF00D;
    send(1'b0, 8'h08, 32'h0, '{32'hCAFEF00D, 2'b00, 1'b0}, e0);
    recv("post_rst", seen);
    chk("post_rst_rsp_cyc", 64'(seen), 64'(e0 + 2));
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
